// File: rtl/uart_rx_engine.sv
// Oversampled UART receiver feeding an FWFT RX FIFO; a word is written on the clock after its final stop-bit sample.
// The serial line cannot be stalled: a push into a full FIFO is dropped and sets overrun. UART_RX_BREAK_DETECT_EN enables break detection.
module uart_rx_engine #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 20
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          cfg_rx_en,
  input  logic [3:0]                    cfg_baud_sel,
  input  logic [1:0]                    cfg_frame_type,
  input  logic [1:0]                    cfg_parity_type,
  input  logic                          cfg_stop_type,
  input  logic                          rx,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [7:0]                    rd_data,
  output logic                          rd_frame_err,
  output logic                          rd_parity_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic                          rx_busy,
  output logic                          break_det
);

  localparam int OS_W  = $clog2(OVERSAMPLE) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK
  } state_t;

  function automatic logic [DIV_W-1:0] calc_div(input int idx);
    int baud;
    case (idx)
      0: baud = 200;       1: baud = 300;       2: baud = 600;       3: baud = 1200;
      4: baud = 1800;      5: baud = 2400;      6: baud = 4800;      7: baud = 9600;
      8: baud = 19200;     9: baud = 28800;     10: baud = 38400;    11: baud = 57600;
      12: baud = 76800;    13: baud = 115200;   14: baud = 230400;   default: baud = 460800;
    endcase
    return DIV_W'((CLK_FREQ_HZ + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE) - 1);
  endfunction

  logic [DIV_W-1:0] div_tab [16];
  for (genvar g = 0; g < 16; g++) begin : g_div
    assign div_tab[g] = calc_div(g);
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q, fall;
  logic [DIV_W-1:0]       tick_cnt_q, div_q;
  logic                   tick, samp, maj;
  logic [OS_W-1:0]        os_cnt_q;
  logic [1:0]             smp_q;
  state_t                 state_q, state_d;
  logic                   start_go, push_d, push_q, is_brk, brk_exit;
  logic [2:0]             bit_cnt_q, last_bit_q;
  logic                   par_en_q, par_odd_q, stop2_q;
  logic [7:0]             data_q;
  logic                   ferr_q, perr_q;
  logic [9:0]             wr_word_q;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign fall     = rx_prev_q & ~rx_s;
  assign tick     = (tick_cnt_q == '0);
  // Decision point is the tick that takes sample OVERSAMPLE/2+1, so the three centre samples are available.
  assign samp     = tick && (os_cnt_q == OS_W'(OVERSAMPLE / 2));
  assign maj      = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s) | (smp_q[0] & rx_s);
  assign start_go = (state_q == S_IDLE) && cfg_rx_en && fall;
  assign push_d   = cfg_rx_en && samp && !is_brk &&
                    ((state_q == S_STOP1 && !stop2_q) || state_q == S_STOP2);
  assign rx_busy  = (state_q != S_IDLE);

`ifdef UART_RX_BREAK_DETECT_EN
  logic            all_low_q, brk_q;
  logic [OS_W-1:0] hi_cnt_q;

  assign is_brk    = cfg_rx_en && (state_q == S_STOP1) && samp && all_low_q && !maj;
  assign brk_exit  = tick && rx_s && (hi_cnt_q == OS_W'(OVERSAMPLE - 1));
  assign break_det = brk_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      all_low_q <= 1'b0;
      brk_q     <= 1'b0;
      hi_cnt_q  <= '0;
    end else begin
      brk_q <= is_brk;
      if (start_go)
        all_low_q <= 1'b1;
      else if (samp && maj && (state_q == S_DATA || state_q == S_PARITY))
        all_low_q <= 1'b0;
      if (state_q != S_BREAK)
        hi_cnt_q <= '0;
      else if (tick)
        hi_cnt_q <= rx_s ? hi_cnt_q + 1'b1 : '0;
    end
  end
`else
  assign is_brk    = 1'b0;
  assign brk_exit  = 1'b0;
  assign break_det = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_go) state_d = S_START;
      S_START:  if (samp) state_d = maj ? S_IDLE : S_DATA;
      S_DATA:   if (samp && bit_cnt_q == last_bit_q) state_d = par_en_q ? S_PARITY : S_STOP1;
      S_PARITY: if (samp) state_d = S_STOP1;
      S_STOP1:  if (samp) state_d = is_brk ? S_BREAK : (stop2_q ? S_STOP2 : S_IDLE);
      S_STOP2:  if (samp) state_d = S_IDLE;
      S_BREAK:  if (brk_exit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (!cfg_rx_en) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      tick_cnt_q <= '0;
      div_q      <= '0;
      os_cnt_q   <= '0;
      smp_q      <= '1;
      bit_cnt_q  <= '0;
      last_bit_q <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      push_q     <= 1'b0;
      wr_word_q  <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q <= rx_s;
      push_q    <= push_d;
      if (start_go) begin
        tick_cnt_q <= div_tab[cfg_baud_sel];
        div_q      <= div_tab[cfg_baud_sel];
        os_cnt_q   <= '0;
        bit_cnt_q  <= '0;
        last_bit_q <= {1'b1, cfg_frame_type};
        par_en_q   <= (cfg_parity_type == 2'b01) || (cfg_parity_type == 2'b10);
        par_odd_q  <= (cfg_parity_type == 2'b10);
        stop2_q    <= cfg_stop_type;
        data_q     <= '0;
        ferr_q     <= 1'b0;
        perr_q     <= 1'b0;
      end else begin
        if (tick) begin
          tick_cnt_q <= div_q;
          os_cnt_q   <= (os_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + 1'b1;
          smp_q      <= {smp_q[0], rx_s};
        end else begin
          tick_cnt_q <= tick_cnt_q - 1'b1;
        end
        if (samp) begin
          case (state_q)
            S_DATA: begin
              data_q[bit_cnt_q] <= maj;
              bit_cnt_q         <= bit_cnt_q + 1'b1;
            end
            S_PARITY:         perr_q <= maj ^ (^data_q) ^ par_odd_q;
            S_STOP1, S_STOP2: ferr_q <= ferr_q | ~maj;
            default: ;
          endcase
        end
      end
      if (push_d) wr_word_q <= {ferr_q | ~maj, perr_q, data_q};
    end
  end

  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop, full, wr_en;
  logic [9:0]       head;

  assign pop        = rd_valid && rd_ready;
  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign wr_en      = push_q && (!full || pop);
  assign head       = mem_q[rd_ptr_q];
  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? head[7:0] : 8'h00;
  assign rd_parity_err = rd_valid & head[8];
  assign rd_frame_err  = rd_valid & head[9];
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_word_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(wr_en) - CNT_W'(pop);
      if (push_q && full && !pop) overrun <= 1'b1;
      else if (clr_overrun)       overrun <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Parametrised hardware UART receiver with an integrated RX FIFO. It replaces the bench-side mid-bit sampling model with synthesizable oversampled reception.
- Sits behind the control/status register tile. Consumes the control-register fields baud select, frame type, parity and stop type.
- Delivers received words with per-word error flags through a valid/ready read port.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency used to build the baud divisor table.
- OVERSAMPLE, 16, sample ticks per bit; even, range 8..32.
- FIFO_DEPTH, 8, RX FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, rx input synchronizer flops; at least 2.
- DIV_W, 20, width of the baud tick divisor counter.

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- cfg_rx_en  in  1  receiver enable
- cfg_baud_sel  in  4  index into {200,300,600,1200,1800,2400,4800,9600,19200,28800,38400,57600,76800,115200,230400,460800}
- cfg_frame_type  in  2  00=5, 01=6, 10=7, 11=8 data bits
- cfg_parity_type  in  2  00=none, 01=even, 10=odd, 11=none (reserved)
- cfg_stop_type  in  1  0=1 stop bit, 1=2 stop bits
- rx  in  1  asynchronous serial input, idle high
- rd_valid  out  1  FIFO head valid
- rd_ready  in  1  consumer accepts head
- rd_data  out  8  received data, LSB-aligned, unused MSBs zero
- rd_frame_err  out  1  head word had a low stop bit
- rd_parity_err  out  1  head word parity mismatch
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- overrun  out  1  sticky: a word was dropped because the FIFO was full
- clr_overrun  in  1  one-cycle pulse that clears overrun
- rx_busy  out  1  frame reception in progress
- break_det  out  1  break pulse (see Optional Feature)

Behaviour:
- Clock and reset: single clock domain clk; reset arst_n is asynchronous, active-low.
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, tick counter 0, synchronizer flops 1.
- Baud tick: divisor = round(CLK_FREQ_HZ/(BAUD*OVERSAMPLE)) - 1, from an elaboration-time table indexed by cfg_baud_sel. The tick counter counts down and reloads.
- Config latching: configuration is latched at start-bit detection. Config changes mid-frame take effect on the next frame.
- FSM states:
  - IDLE: falling edge of synchronized rx with cfg_rx_en=1 -> START. Clear the oversample counter and resync the tick counter.
  - START: at sample OVERSAMPLE/2, check majority of samples OVERSAMPLE/2-1..+1. If high (false start) -> IDLE; else -> DATA.
  - DATA: sample every OVERSAMPLE ticks at bit centre (majority of 3), LSB first, frame-bits times. Then -> PARITY if parity is enabled, else -> STOP1.
  - PARITY: compare the received bit against the computed parity (even: XOR of data bits; odd: inverted). Mismatch sets parity_err. Then -> STOP1.
  - STOP1: a low sample sets frame_err. If cfg_stop_type=1 -> STOP2; else push and -> IDLE.
  - STOP2: a low sample sets frame_err. Push and -> IDLE.
- Push timing: the word {frame_err, parity_err, data} enters the FIFO on the clock after the final stop-bit sample. rd_valid rises 1 cycle after the push.
- Return to IDLE: IDLE may detect a new start edge immediately; rx must be seen high before a new falling edge counts.
- rx_busy: 1 in START through STOP2.
- Read port: FWFT. rd_data and flags are stable while rd_valid=1 and rd_ready=0. A pop occurs on rd_valid & rd_ready.
- FIFO full at push:
  - If a pop occurs in the same cycle, the push is accepted and the count is unchanged.
  - Otherwise the word is dropped and overrun is set.
- Simultaneous clr_overrun and a new overrun: set wins.
- cfg_rx_en deasserted mid-frame: abort to IDLE on the next cycle, no push. FIFO contents are retained.
- fifo_count saturates at FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined: if all data bits, parity (if enabled) and STOP1 sample low, the frame is a break.
  - No push; break_det pulses for 1 cycle.
  - FSM waits in a BREAK state until synchronized rx has been high for OVERSAMPLE consecutive ticks, then -> IDLE.
- Undefined: break_det tied 0. The same frame is pushed as data 0 with frame_err=1, and the FSM returns to IDLE normally.

Test Plan:
- Reset, 100 MHz, sel=7, 8N1, send 0xA5 -> divisor 650. One FIFO entry 0xA5, no flags. rd_valid rises about 10 bit times (~1.04 ms) after the start edge.
- sel=13 (115200), frame=00, even parity, 2 stop bits, send 0x15 with a wrong parity bit -> rd_data=0x15, rd_parity_err=1, rd_frame_err=0.
- 8N1, STOP1 driven low for a byte 0x3C -> rd_data=0x3C, rd_frame_err=1.
- rd_ready=0, send FIFO_DEPTH+1=9 bytes 0x00..0x08 -> fifo_count=8, overrun=1, and 0x08 is dropped. Drain reads 0x00..0x07. clr_overrun -> overrun=0.
- rx low pulse of 3 oversample ticks -> false start, no push, rx_busy back to 0. Deassert cfg_rx_en during DATA -> no push, FIFO unchanged.
- With UART_RX_BREAK_DETECT_EN: rx low for 2 frame times -> break_det pulses once, fifo_count stays 0. After rx has been high 16 ticks, 0x5A is received correctly.
